// File: rtl/wb_pkg.sv
// Shared writeback definitions: source-select codes, sequencer state type and
// source legality check, also used by the control unit and the MUX2 select logic.
package wb_pkg;

  localparam logic [2:0] WB_SRC_ULA   = 3'd0;
  localparam logic [2:0] WB_SRC_LS    = 3'd1;
  localparam logic [2:0] WB_SRC_HI    = 3'd2;
  localparam logic [2:0] WB_SRC_LO    = 3'd3;
  localparam logic [2:0] WB_SRC_SHIFT = 3'd4;
  localparam logic [2:0] WB_SRC_LT32  = 3'd5;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WAIT  = 2'd1,
    WB_WRITE = 2'd2,
    WB_ERR   = 2'd3
  } wb_state_t;

  function automatic logic wb_src_legal(input logic [2:0] src);
    return (src <= WB_SRC_LT32);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// WAIT-duration counter for the writeback sequencer; only built when
// WB_TIMEOUT_EN is defined. expire_o flags the last allowed WAIT cycle.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of WAIT cycles already completed
  assign expire_o = enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file writeback sequencer: latches source/destination, waits for the
// source to be ready, issues one RegWrite. Optional WAIT timeout: WB_TIMEOUT_EN.
module writeback_ctrl
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int REG_ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_req,
  input  logic [2:0]            wb_src,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic                  ls_ready,
  input  logic                  shift_ready,
  input  logic                  hilo_ready,
  output logic [2:0]            WriteData,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  RegWrite,
  output logic                  wb_busy,
  output logic                  wb_done,
  output logic                  wb_err
);

  wb_state_t             state_q;
  logic [2:0]            wdata_q;
  logic [REG_ADDR_W-1:0] wreg_q;
  logic                  regwrite_q;
  logic                  done_q;
  logic                  err_q;
  logic                  busy_q;

  logic [2:0]            sel_src;
  logic                  src_ready_d;
  logic                  tmo_expire;

  // In IDLE the incoming request is judged; afterwards the latched source is.
  always_comb begin
    sel_src     = (state_q == WB_IDLE) ? wb_src : wdata_q;
    src_ready_d = 1'b1;
    case (sel_src)
      WB_SRC_LS:           src_ready_d = ls_ready;
      WB_SRC_HI, WB_SRC_LO: src_ready_d = hilo_ready;
      WB_SRC_SHIFT:        src_ready_d = shift_ready;
      default:             src_ready_d = 1'b1;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  wb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q != WB_WAIT),
    .enable_i (state_q == WB_WAIT),
    .expire_o (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= WB_IDLE;
      wdata_q    <= 3'd0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      regwrite_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        WB_IDLE: begin
          if (wb_req) begin
            wdata_q <= wb_src;
            wreg_q  <= wb_dst;
            busy_q  <= 1'b1;
            if (!wb_src_legal(wb_src)) begin
              state_q <= WB_ERR;
              err_q   <= 1'b1;
            end else if (src_ready_d) begin
              state_q    <= WB_WRITE;
              regwrite_q <= (wb_dst != '0);
              done_q     <= 1'b1;
            end else begin
              state_q <= WB_WAIT;
            end
          end
        end
        WB_WAIT: begin
          // Ready in the final counted cycle takes priority over the timeout
          if (src_ready_d) begin
            state_q    <= WB_WRITE;
            regwrite_q <= (wreg_q != '0);
            done_q     <= 1'b1;
          end else if (tmo_expire) begin
            state_q <= WB_ERR;
            err_q   <= 1'b1;
          end
        end
        WB_WRITE, WB_ERR: begin
          state_q <= WB_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= WB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign WriteData = wdata_q;
  assign WriteReg  = wreg_q;
  assign RegWrite  = regwrite_q;
  assign wb_done   = done_q;
  assign wb_err    = err_q;
  assign wb_busy   = busy_q;

endmodule

// File: doc/writeback_ctrl.md
# writeback_ctrl

Register-file writeback sequencer for the multicycle datapath. Accepts a writeback request from the main control unit and drives the write-data mux select, destination register and `RegWrite`. Waits for multi-cycle sources (load/store unit, shifter, HI/LO from mult/div) to report ready, then performs exactly one register write and signals completion. It is the single owner of the `WriteData` select and `RegWrite`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum consecutive WAIT cycles before abort; only used with `WB_TIMEOUT_EN`; legal range 2..255.
- `REG_ADDR_W`, 5: register-address width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `wb_req`  in  1  writeback request; sampled only in IDLE.
- `wb_src`  in  3  source code: 000 ULA, 001 LS, 010 HI, 011 LO, 100 Shift, 101 LT32; 110/111 illegal.
- `wb_dst`  in  REG_ADDR_W  destination register.
- `ls_ready`  in  1  load/store result valid.
- `shift_ready`  in  1  shifter result valid.
- `hilo_ready`  in  1  HI/LO stable (mult/div not busy).
- `WriteData`  out  3  mux select, equal to the latched source.
- `WriteReg`  out  REG_ADDR_W  latched destination.
- `RegWrite`  out  1  register-file write enable, one-cycle pulse.
- `wb_busy`  out  1  high in every state except IDLE.
- `wb_done`  out  1  one-cycle pulse on successful completion.
- `wb_err`  out  1  one-cycle pulse: illegal source or timeout.

## Operation
- States: IDLE, WAIT, WRITE, ERR.
- Required ready per source: ULA and LT32 always ready; LS → `ls_ready`; HI/LO → `hilo_ready`; Shift → `shift_ready`.
- IDLE, `wb_req`=1:
  - Latch `wb_src` into `WriteData` and `wb_dst` into `WriteReg`.
  - Illegal source → ERR.
  - Required ready high at that edge → WRITE.
  - Otherwise → WAIT.
- WAIT: required ready high → WRITE; otherwise stay. Ready signals are sampled registered, never combinationally forwarded to outputs.
- WRITE, one cycle:
  - `RegWrite`=1 unless `WriteReg`==0; writes to register 0 are suppressed.
  - `wb_done`=1 in both cases.
  - Next state IDLE.
- ERR, one cycle: `wb_err`=1, `RegWrite`=0, `wb_done`=0; next state IDLE.
- `wb_req` outside IDLE is ignored; no queuing. The control unit must hold off while `wb_busy`=1.
- `WriteData`/`WriteReg` hold their latched values until the next accepted request, including after completion.
- Reset (`reset`=0 at an edge) overrides everything, including mid-WAIT or mid-WRITE:
  - State → IDLE.
  - `WriteData`=000, `WriteReg`=0.
  - `RegWrite`, `wb_busy`, `wb_done`, `wb_err` = 0.
  - Timeout counter cleared.
  - An interrupted write is not performed.

## Timing
- Request accepted at edge N.
- Always-ready source: WRITE during cycle N..N+1 (`RegWrite` visible one cycle after request). Latency 1.
- Source ready k cycles after acceptance: `RegWrite` asserted in cycle N+k+1.
- Back-to-back: IDLE re-entered after WRITE/ERR, so minimum request spacing is 2 cycles.
- All outputs are registered or decoded from registered state only.

## Configuration
- `WB_TIMEOUT_EN` defined:
  - 8-bit counter increments each WAIT cycle and clears on leaving WAIT.
  - If WAIT has lasted `TIMEOUT_CYCLES` cycles with ready still low, the next state is ERR and no write occurs.
  - Ready arriving in the final counted cycle wins; the block goes to WRITE.
- `WB_TIMEOUT_EN` undefined: no counter, WAIT is unbounded, and `wb_err` fires only for illegal sources.

## Structure
- Shared package `wb_pkg`:
  - Source-code localparams `WB_SRC_ULA` … `WB_SRC_LT32`.
  - State enum `wb_state_t`.
  - Function `wb_src_legal()`.
- The package is shared with the control unit and the MUX2 selection logic.
- One optional sub-module, `wb_timeout_cnt` (clear, enable, expire), instantiated only under `WB_TIMEOUT_EN`.

## Test plan
- Reset: hold `reset`=0 with `wb_req`=1, `wb_src`=001 → all outputs 0 and `WriteData`=000 throughout.
- ULA write: `wb_req`, `wb_src`=000, `wb_dst`=9 → next cycle `RegWrite`=1, `WriteData`=000, `WriteReg`=9, `wb_done`=1; back in IDLE the following cycle.
- LS wait: `wb_src`=001, `wb_dst`=4, `ls_ready` rises 3 cycles later → `wb_busy` high 4 cycles, `RegWrite` exactly once in cycle 4, `WriteData`=001 held.
- Register 0 and illegal source:
  - `wb_dst`=0, `wb_src`=101 → `wb_done`=1 with `RegWrite`=0.
  - `wb_src`=111 → `wb_err` pulse, no `RegWrite`, no `wb_done`.
- Reset mid-WAIT and ignored request:
  - `wb_src`=010, `hilo_ready`=0, assert `reset` after 2 cycles → IDLE, `RegWrite` never high.
  - Second `wb_req` during WAIT → ignored.
- `WB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4:
  - `wb_src`=100 with `shift_ready`=0 → `wb_err` after 4 WAIT cycles.
  - `shift_ready` raised in WAIT cycle 4 → WRITE instead of ERR.
